// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: shifts a WIDTH-bit word out one bit per clock,
// MSB or LSB first, with an optional trailing even-parity bit.
module bit_serializer #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned LSB_FIRST = 0,
   parameter int unsigned PARITY    = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             flush,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
);

   localparam int unsigned FLEN = WIDTH + PARITY;
   localparam int unsigned CW   = $clog2(FLEN);

   localparam logic IDLE  = 1'b0;
   localparam logic SHIFT = 1'b1;

   logic             state,  state_n;
   logic [CW-1:0]    cnt,    cnt_n;
   logic [WIDTH-1:0] shreg,  shreg_n;
   logic             par,    par_n;
   logic             sout_n, valid_n, last_n;
   logic [WIDTH-1:0] rev, ordered;
   logic             accept;

   // Bit-reverse once so the shifter always emits from its top bit
   for (genvar g = 0; g < WIDTH; g++) begin : g_rev
      assign rev[g] = din[WIDTH-1-g];
   end
   assign ordered = (LSB_FIRST != 0) ? rev : din;

   // Ready in IDLE or while the final bit is on the line, so frames chain gap-free
   assign din_ready = rst_n & ~flush & ((state == IDLE) | sout_last);
   assign accept    = din_valid & din_ready;
   assign busy      = (state == SHIFT);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      par_n   = par;
      sout_n  = sout;
      valid_n = sout_valid;
      last_n  = sout_last;
      if (flush) begin
         state_n = IDLE;
         cnt_n   = '0;
         sout_n  = 1'b0;
         valid_n = 1'b0;
         last_n  = 1'b0;
      end else if (accept) begin
         state_n = SHIFT;
         cnt_n   = '0;
         shreg_n = {ordered[WIDTH-2:0], 1'b0};
         par_n   = ^din;
         sout_n  = ordered[WIDTH-1];
         valid_n = 1'b1;
         last_n  = 1'b0;
      end else if (state == SHIFT) begin
         if (sout_last) begin
            state_n = IDLE;
            cnt_n   = '0;
            sout_n  = 1'b0;
            valid_n = 1'b0;
            last_n  = 1'b0;
         end else begin
            cnt_n  = cnt + CW'(1);
            last_n = (cnt_n == CW'(FLEN - 1));
            // Data bits remain until the counter passes WIDTH-1; then the parity bit
            if (32'(cnt) < WIDTH - 1) begin
               sout_n  = shreg[WIDTH-1];
               shreg_n = {shreg[WIDTH-2:0], 1'b0};
            end else begin
               sout_n = par;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sout_last  <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         shreg      <= shreg_n;
         par        <= par_n;
         sout       <= sout_n;
         sout_valid <= valid_n;
         sout_last  <= last_n;
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (MSB-first, LSB-first, parity)
// checked each cycle against a frame-queue model plus literal frame checks.
module tb_bit_serializer;

   logic       clk;
   logic       rst_n;
   logic [7:0] din_a  [3];
   logic       dv_a   [3];
   logic       fl_a   [3];
   logic       rdy_a  [3];
   logic       sout_a [3];
   logic       vld_a  [3];
   logic       last_a [3];
   logic       busy_a [3];

   int errors = 0;
   int checks = 0;

   bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY(0)) u0 (
      .clk(clk), .rst_n(rst_n), .din(din_a[0]), .din_valid(dv_a[0]), .din_ready(rdy_a[0]),
      .flush(fl_a[0]), .sout(sout_a[0]), .sout_valid(vld_a[0]), .sout_last(last_a[0]), .busy(busy_a[0]));
   bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY(0)) u1 (
      .clk(clk), .rst_n(rst_n), .din(din_a[1]), .din_valid(dv_a[1]), .din_ready(rdy_a[1]),
      .flush(fl_a[1]), .sout(sout_a[1]), .sout_valid(vld_a[1]), .sout_last(last_a[1]), .busy(busy_a[1]));
   bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY(1)) u2 (
      .clk(clk), .rst_n(rst_n), .din(din_a[2]), .din_valid(dv_a[2]), .din_ready(rdy_a[2]),
      .flush(fl_a[2]), .sout(sout_a[2]), .sout_valid(vld_a[2]), .sout_last(last_a[2]), .busy(busy_a[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, d, $time, act, exp);
      end
   endtask

   function automatic bit lsb_of(input int d);
      return d == 1;
   endfunction
   function automatic bit par_of(input int d);
      return d == 2;
   endfunction
   function automatic int flen(input int d);
      return par_of(d) ? 9 : 8;
   endfunction

   // Bit i of the result is the i-th bit transmitted on the line
   function automatic logic [31:0] frame_bits(input logic [7:0] d, input bit lsb, input bit par);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[i] = lsb ? d[i] : d[7-i];
      if (par) f[8] = ^d;
      return f;
   endfunction

   // Model: current frame and how many of its bits (including the one on the line) remain
   logic [31:0] mfr [3];
   int          rem [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 3; d++) rem[d] = 0;
      end else begin
         for (int d = 0; d < 3; d++) begin
            bit mrdy;
            mrdy = !fl_a[d] && rem[d] <= 1;
            if (fl_a[d]) rem[d] = 0;
            else begin
               if (rem[d] > 0) rem[d]--;
               if (dv_a[d] && mrdy) begin
                  mfr[d] = frame_bits(din_a[d], lsb_of(d), par_of(d));
                  rem[d] = flen(d);
               end
            end
         end
      end
   end

   logic [31:0] rxb [3];
   logic [31:0] rxl [3];
   int          rxn [3];

   // Per-cycle compare, plus capture of what each DUT put on the line
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         logic e_vld, e_bit, e_last, e_rdy;
         e_vld  = rem[d] > 0;
         e_bit  = e_vld ? mfr[d][flen(d) - rem[d]] : 1'b0;
         e_last = rem[d] == 1;
         e_rdy  = rst_n && !fl_a[d] && rem[d] <= 1;
         chk("sout_valid", d, 32'(vld_a[d]),  32'(e_vld));
         chk("sout",       d, 32'(sout_a[d]), 32'(e_bit));
         chk("sout_last",  d, 32'(last_a[d]), 32'(e_last));
         chk("busy",       d, 32'(busy_a[d]), 32'(e_vld));
         chk("din_ready",  d, 32'(rdy_a[d]),  32'(e_rdy));
         if (vld_a[d] === 1'b1 && rxn[d] < 32) begin
            rxb[d][rxn[d]] = sout_a[d];
            if (last_a[d] === 1'b1) rxl[d][rxn[d]] = 1'b1;
            rxn[d]++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic clr_rx();
      for (int d = 0; d < 3; d++) begin
         rxb[d] = '0;
         rxl[d] = '0;
         rxn[d] = 0;
      end
   endtask

   task automatic send1(input int d, input logic [7:0] w);
      din_a[d] = w;
      dv_a[d]  = 1'b1;
      step(1);
      dv_a[d]  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         din_a[d] = '0;
         dv_a[d]  = 1'b0;
         fl_a[d]  = 1'b0;
      end
      clr_rx();
      #1;
      chk("reset_valid", 0, 32'(vld_a[0]), 32'd0);
      chk("reset_ready", 0, 32'(rdy_a[0]), 32'd0);
      chk("reset_busy",  0, 32'(busy_a[0]), 32'd0);

      // Model frame builder pinned against hand-derived bit orders
      chk("model_msb01", 0, frame_bits(8'h01, 1'b0, 1'b0), 32'h080);
      chk("model_lsb80", 1, frame_bits(8'h80, 1'b1, 1'b0), 32'h080);
      chk("model_par07", 2, frame_bits(8'h07, 1'b0, 1'b1), 32'h1E0);
      chk("model_par03", 2, frame_bits(8'h03, 1'b0, 1'b1), 32'h0C0);

      step(3);
      rst_n = 1'b1;

      // A5 MSB-first, accepted on the first edge after reset release
      send1(0, 8'hA5);
      step(10);
      chk("a5_count", 0, 32'(rxn[0]), 32'd8);
      chk("a5_bits",  0, rxb[0], 32'h0A5);
      chk("a5_last",  0, rxl[0], 32'h080);

      // LSB-first 01 then 80
      clr_rx();
      send1(1, 8'h01);
      step(10);
      chk("lsb01_bits", 1, rxb[1], 32'h001);
      chk("lsb01_last", 1, rxl[1], 32'h080);
      clr_rx();
      send1(1, 8'h80);
      step(10);
      chk("lsb80_bits", 1, rxb[1], 32'h080);

      // Back-to-back FF then 00 with din_valid held
      clr_rx();
      din_a[0] = 8'hFF;
      dv_a[0]  = 1'b1;
      step(1);
      din_a[0] = 8'h00;
      step(8);
      dv_a[0]  = 1'b0;
      step(10);
      chk("b2b_count", 0, 32'(rxn[0]), 32'd16);
      chk("b2b_bits",  0, rxb[0], 32'h00FF);
      chk("b2b_last",  0, rxl[0], 32'h8080);

      // Parity frames
      clr_rx();
      send1(2, 8'h07);
      step(11);
      chk("par07_count", 2, 32'(rxn[2]), 32'd9);
      chk("par07_bits",  2, rxb[2], 32'h1E0);
      chk("par07_last",  2, rxl[2], 32'h100);
      clr_rx();
      send1(2, 8'h03);
      step(11);
      chk("par03_bits",  2, rxb[2], 32'h0C0);

      // Reset mid-frame, then a fresh word from bit 0
      clr_rx();
      send1(0, 8'hA5);
      step(2);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 0, 32'(vld_a[0]), 32'd0);
      chk("rst_mid_busy",  0, 32'(busy_a[0]), 32'd0);
      chk("rst_mid_ready", 0, 32'(rdy_a[0]), 32'd0);
      chk("rst_mid_count", 0, 32'(rxn[0]), 32'd3);
      chk("rst_mid_bits",  0, rxb[0], 32'h005);
      step(2);
      rst_n = 1'b1;
      clr_rx();
      send1(0, 8'h3C);
      step(10);
      chk("post_rst_count", 0, 32'(rxn[0]), 32'd8);
      chk("post_rst_bits",  0, rxb[0], 32'h03C);

      // Flush on the edge that would accept AA during the last-bit cycle
      clr_rx();
      send1(0, 8'h5A);
      step(7);
      din_a[0] = 8'hAA;
      dv_a[0]  = 1'b1;
      fl_a[0]  = 1'b1;
      #1;
      chk("flush_ready", 0, 32'(rdy_a[0]), 32'd0);
      step(1);
      dv_a[0]  = 1'b0;
      fl_a[0]  = 1'b0;
      chk("flush_valid", 0, 32'(vld_a[0]), 32'd0);
      chk("flush_busy",  0, 32'(busy_a[0]), 32'd0);
      step(10);
      chk("flush_count", 0, 32'(rxn[0]), 32'd8);
      chk("flush_bits",  0, rxb[0], 32'h05A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
